// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA timing/pattern slice.
// Defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_BLACK    = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_CHECKER  = 2'd2,
    MODE_GRADIENT = 2'd3
  } mode_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam rgb_t [7:0] BAR_COLOURS = {
    12'h000, 12'h00F, 12'hF00, 12'hF0F,
    12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
  };

  localparam rgb_t RGB_BLACK = 12'h000;
  localparam rgb_t RGB_WHITE = 12'hFFF;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle: enable/mode in, RGB, syncs and coordinates out.
interface vga_timing_gen_if #(
  parameter int HW = 10,
  parameter int VW = 10
);
  logic          pix_en;
  logic [1:0]    mode;
  logic [3:0]    r;
  logic [3:0]    g;
  logic [3:0]    b;
  logic          hs;
  logic          vs;
  logic          de;
  logic [HW-1:0] x;
  logic [VW-1:0] y;
  logic          frame_start;

  modport master (
    input  pix_en, mode,
    output r, g, b, hs, vs, de, x, y, frame_start
  );

  modport slave (
    output pix_en, mode,
    input  r, g, b, hs, vs, de, x, y, frame_start
  );
endinterface

// File: rtl/vga_pattern.sv
// Combinational test-pattern engine: raw counters + mode -> one RGB pixel.
// Blanked pixels are forced black here so the top only registers the result.
module vga_pattern
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int CHK_SHIFT = 5,
  parameter int HW        = 10,
  parameter int VW        = 10
) (
  input  logic [HW-1:0] hc,
  input  logic [VW-1:0] vc,
  input  logic          de,
  input  mode_e         mode,
  output rgb_t          rgb
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0] bar;
  logic       chk;
  logic [3:0] h_hi;
  logic [3:0] v_hi;

  // Threshold chain instead of a divider; bar widths are compile-time constants.
  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++)
      if (hc >= HW'(k * BAR_W)) bar = 3'(k);
  end

  assign chk  = 1'(hc >> CHK_SHIFT) ^ 1'(vc >> CHK_SHIFT);
  assign h_hi = 4'(hc >> 4);
  assign v_hi = 4'(vc >> 4);

  always_comb begin
    rgb = RGB_BLACK;
    if (de) begin
      case (mode)
        MODE_BARS:     rgb = BAR_COLOURS[bar];
        MODE_CHECKER:  rgb = chk ? RGB_BLACK : RGB_WHITE;
        MODE_GRADIENT: rgb = '{r: h_hi, g: v_hi, b: h_hi ^ v_hi};
        default:       rgb = RGB_BLACK;
      endcase
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync generator with built-in test patterns.
// Every output is registered from the counter state seen on the same enabled edge.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int CHK_SHIFT = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  vga_timing_gen_if.master vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  if (H_ACTIVE < 8 || (H_ACTIVE % 8) != 0 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || CHK_SHIFT < 0) begin : g_param_err
    $error("vga_timing_gen: illegal timing parameters");
  end

  logic [HW-1:0] hc;
  logic [VW-1:0] vc;
  logic          first_px;
  logic          de_c;
  logic          hs_c;
  logic          vs_c;
  mode_e         active_mode;
  mode_e         eff_mode;
  rgb_t          pix;

  rgb_t          rgb_q;
  logic          hs_q;
  logic          vs_q;
  logic          de_q;
  logic [HW-1:0] x_q;
  logic [VW-1:0] y_q;
  logic          fs_q;

  assign first_px = (hc == '0) && (vc == '0);
  assign de_c     = (hc < H_VIS) && (vc < V_VIS);
  assign hs_c     = (hc >= HS_BEG) && (hc < HS_END);
  assign vs_c     = (vc >= VS_BEG) && (vc < VS_END);

  // The first pixel of a frame already uses the freshly sampled mode, so a
  // frame is rendered in one mode from its very first pixel.
  assign eff_mode = first_px ? mode_e'(vif.mode) : active_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc <= '0;
      vc <= '0;
    end else if (vif.pix_en) begin
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? '0 : vc + VW'(1);
      end else begin
        hc <= hc + HW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     active_mode <= MODE_BLACK;
    else if (vif.pix_en && first_px) active_mode <= mode_e'(vif.mode);
  end

  vga_pattern #(
    .H_ACTIVE (H_ACTIVE),
    .CHK_SHIFT(CHK_SHIFT),
    .HW       (HW),
    .VW       (VW)
  ) u_pattern (
    .hc  (hc),
    .vc  (vc),
    .de  (de_c),
    .mode(eff_mode),
    .rgb (pix)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= RGB_BLACK;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      de_q  <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      fs_q  <= 1'b0;
    end else if (vif.pix_en) begin
      rgb_q <= pix;
      hs_q  <= hs_c ? HS_POL : ~HS_POL;
      vs_q  <= vs_c ? VS_POL : ~VS_POL;
      de_q  <= de_c;
      x_q   <= de_c ? hc : '0;
      y_q   <= de_c ? vc : '0;
      fs_q  <= first_px;
    end
  end

  assign vif.r           = rgb_q.r;
  assign vif.g           = rgb_q.g;
  assign vif.b           = rgb_q.b;
  assign vif.hs          = hs_q;
  assign vif.vs          = vs_q;
  assign vif.de          = de_q;
  assign vif.x           = x_q;
  assign vif.y           = y_q;
  assign vif.frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three parameter sets checked against an arithmetic
// model indexed by the number of enabled pixels since reset.
module tb_vga_timing_gen;

  typedef struct packed {
    int ha, hf, hsy, hb, va, vf, vsy, vb, cs;
    bit hp, vp;
  } cfg_t;

  typedef struct packed {
    logic [3:0]  r, g, b;
    logic        hs, vs, de;
    logic [15:0] x, y;
    logic        fs;
  } exp_t;

  localparam cfg_t CA = '{ha:640, hf:16, hsy:96, hb:48, va:8,  vf:2, vsy:2, vb:3, cs:5, hp:1'b0, vp:1'b0};
  localparam cfg_t CB = '{ha:128, hf:4,  hsy:8,  hb:4,  va:64, vf:1, vsy:1, vb:2, cs:5, hp:1'b0, vp:1'b0};
  localparam cfg_t CS = '{ha:8,   hf:1,  hsy:2,  hb:1,  va:4,  vf:1, vsy:1, vb:1, cs:1, hp:1'b1, vp:1'b1};

  localparam int HTA = 800, VTA = 15, FTA = HTA * VTA;
  localparam int HTB = 144, VTB = 68;
  localparam int HTS = 12,  VTS = 7,  FTS = HTS * VTS;
  localparam int FTB = HTB * VTB;

  logic clk = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1, rst_s = 1'b1;
  int   pa, pb, ps, fma, fmb, fms;
  exp_t ea, eb, es;
  int   n_chk = 0, n_fail = 0, cyc = 0;

  vga_timing_gen_if #(.HW($clog2(HTA)), .VW($clog2(VTA))) ifa ();
  vga_timing_gen_if #(.HW($clog2(HTB)), .VW($clog2(VTB))) ifb ();
  vga_timing_gen_if #(.HW($clog2(HTS)), .VW($clog2(VTS))) ifs ();

  vga_timing_gen #(.H_ACTIVE(CA.ha), .H_FP(CA.hf), .H_SYNC(CA.hsy), .H_BP(CA.hb),
                   .V_ACTIVE(CA.va), .V_FP(CA.vf), .V_SYNC(CA.vsy), .V_BP(CA.vb),
                   .HS_POL(CA.hp), .VS_POL(CA.vp), .CHK_SHIFT(CA.cs))
    u_a (.clk(clk), .rst_n(rst_a), .vif(ifa.master));
  vga_timing_gen #(.H_ACTIVE(CB.ha), .H_FP(CB.hf), .H_SYNC(CB.hsy), .H_BP(CB.hb),
                   .V_ACTIVE(CB.va), .V_FP(CB.vf), .V_SYNC(CB.vsy), .V_BP(CB.vb),
                   .HS_POL(CB.hp), .VS_POL(CB.vp), .CHK_SHIFT(CB.cs))
    u_b (.clk(clk), .rst_n(rst_b), .vif(ifb.master));
  vga_timing_gen #(.H_ACTIVE(CS.ha), .H_FP(CS.hf), .H_SYNC(CS.hsy), .H_BP(CS.hb),
                   .V_ACTIVE(CS.va), .V_FP(CS.vf), .V_SYNC(CS.vsy), .V_BP(CS.vb),
                   .HS_POL(CS.hp), .VS_POL(CS.vp), .CHK_SHIFT(CS.cs))
    u_s (.clk(clk), .rst_n(rst_s), .vif(ifs.master));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] bar_tb(int k);
    case (k)
      0: return 12'hFFF;  1: return 12'hFF0;  2: return 12'h0FF;  3: return 12'h0F0;
      4: return 12'hF0F;  5: return 12'hF00;  6: return 12'h00F;  default: return 12'h000;
    endcase
  endfunction

  // Expected outputs after the enabled edge that latched pixel number p (p<0: reset).
  function automatic exp_t model(cfg_t c, int p, int m);
    exp_t e; int ht, vt, hc, vc; logic [11:0] col;
    ht = c.ha + c.hf + c.hsy + c.hb;
    vt = c.va + c.vf + c.vsy + c.vb;
    e = '0; e.hs = ~c.hp; e.vs = ~c.vp;
    if (p < 0) return e;
    hc = p % ht; vc = (p / ht) % vt;
    e.de = (hc < c.ha) && (vc < c.va);
    if (hc >= c.ha + c.hf && hc < c.ha + c.hf + c.hsy) e.hs = c.hp;
    if (vc >= c.va + c.vf && vc < c.va + c.vf + c.vsy) e.vs = c.vp;
    e.fs = (hc == 0) && (vc == 0);
    col = 12'h000;
    if (e.de) begin
      e.x = 16'(hc); e.y = 16'(vc);
      case (m)
        1: col = bar_tb(hc / (c.ha / 8));
        2: col = ((((hc >> c.cs) ^ (vc >> c.cs)) & 1) == 0) ? 12'hFFF : 12'h000;
        3: begin
          col[11:8] = 4'((hc >> 4) & 15);
          col[7:4]  = 4'((vc >> 4) & 15);
          col[3:0]  = col[11:8] ^ col[7:4];
        end
        default: col = 12'h000;
      endcase
    end
    {e.r, e.g, e.b} = col;
    return e;
  endfunction

  function automatic exp_t obs_a();
    exp_t o;
    o.r = ifa.r; o.g = ifa.g; o.b = ifa.b; o.hs = ifa.hs; o.vs = ifa.vs; o.de = ifa.de;
    o.x = 16'(ifa.x); o.y = 16'(ifa.y); o.fs = ifa.frame_start;
    return o;
  endfunction
  function automatic exp_t obs_b();
    exp_t o;
    o.r = ifb.r; o.g = ifb.g; o.b = ifb.b; o.hs = ifb.hs; o.vs = ifb.vs; o.de = ifb.de;
    o.x = 16'(ifb.x); o.y = 16'(ifb.y); o.fs = ifb.frame_start;
    return o;
  endfunction
  function automatic exp_t obs_s();
    exp_t o;
    o.r = ifs.r; o.g = ifs.g; o.b = ifs.b; o.hs = ifs.hs; o.vs = ifs.vs; o.de = ifs.de;
    o.x = 16'(ifs.x); o.y = 16'(ifs.y); o.fs = ifs.frame_start;
    return o;
  endfunction

  // One clock per call; the model advances only on enabled, out-of-reset edges.
  task automatic step_a(input logic en);
    ifa.pix_en = en;
    @(posedge clk);
    if (en && rst_a) begin
      pa++;
      if (pa % FTA == 0) fma = int'(ifa.mode);
      ea = model(CA, pa, fma);
    end
    #1;
  endtask
  task automatic step_b(input logic en);
    ifb.pix_en = en;
    @(posedge clk);
    if (en && rst_b) begin
      pb++;
      if (pb % FTB == 0) fmb = int'(ifb.mode);
      eb = model(CB, pb, fmb);
    end
    #1;
  endtask
  task automatic step_s(input logic en);
    ifs.pix_en = en;
    @(posedge clk);
    if (en && rst_s) begin
      ps++;
      if (ps % FTS == 0) fms = int'(ifs.mode);
      es = model(CS, ps, fms);
    end
    #1;
  endtask

  task automatic reset_a();
    ifa.pix_en = 1'b0; rst_a = 1'b0; #3;
    pa = -1; fma = 0; ea = model(CA, -1, 0);
    @(posedge clk); #1; rst_a = 1'b1;
  endtask
  task automatic reset_b();
    ifb.pix_en = 1'b0; rst_b = 1'b0; #3;
    pb = -1; fmb = 0; eb = model(CB, -1, 0);
    @(posedge clk); #1; rst_b = 1'b1;
  endtask
  task automatic reset_s();
    ifs.pix_en = 1'b0; rst_s = 1'b0; #3;
    ps = -1; fms = 0; es = model(CS, -1, 0);
    @(posedge clk); #1; rst_s = 1'b1;
  endtask

  task automatic test_reset();
    exp_t o;
    ifa.mode = 2'd1; ifb.mode = 2'd3; ifs.mode = 2'd2;
    ifa.pix_en = 1'b1; ifb.pix_en = 1'b1; ifs.pix_en = 1'b1;
    #2; rst_a = 1'b0; rst_b = 1'b0; rst_s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    o = obs_a(); n_chk++;
    if (o !== model(CA, -1, 0)) begin n_fail++; $display("FAIL reset_a: got %h expected %h", o, model(CA, -1, 0)); end
    o = obs_b(); n_chk++;
    if (o !== model(CB, -1, 0)) begin n_fail++; $display("FAIL reset_b: got %h expected %h", o, model(CB, -1, 0)); end
    o = obs_s(); n_chk++;
    if (o !== model(CS, -1, 0)) begin n_fail++; $display("FAIL reset_s: got %h expected %h", o, model(CS, -1, 0)); end
  endtask

  task automatic test_default_timing();
    exp_t o, prev;
    int hs_fall[$], vs_fall[$], fs_at[$];
    int hs_lo0 = 0, vs_lo = 0;
    reset_a();
    ifa.mode = 2'($urandom_range(0, 3));
    prev = obs_a();
    for (int i = 0; i < FTA + HTA + 2; i++) begin
      step_a(1'b1);
      o = obs_a(); n_chk++;
      if (o !== ea) begin n_fail++; $display("FAIL default_model pix %0d: got %h expected %h", pa, o, ea); end
      if (prev.hs && !o.hs) hs_fall.push_back(pa);
      if (prev.vs && !o.vs) vs_fall.push_back(pa);
      if (o.fs) fs_at.push_back(pa);
      if (pa < HTA && !o.hs) hs_lo0++;
      if (pa < FTA && !o.vs) vs_lo++;
      prev = o;
    end
    n_chk++;
    if (hs_fall.size() < 2 || hs_fall[0] != 656 || hs_fall[1] - hs_fall[0] != 800) begin
      n_fail++; $display("FAIL hs_start_period: got start %0d period %0d, expected 656 800", hs_fall[0], hs_fall[1] - hs_fall[0]);
    end
    n_chk++;
    if (hs_lo0 != 96) begin n_fail++; $display("FAIL hs_width: got %0d expected 96", hs_lo0); end
    n_chk++;
    if (vs_fall.size() < 1 || vs_fall[0] != 10 * HTA || vs_lo != 2 * HTA) begin
      n_fail++; $display("FAIL vs_start_width: got start %0d width %0d, expected %0d %0d", vs_fall[0], vs_lo, 10 * HTA, 2 * HTA);
    end
    n_chk++;
    if (fs_at.size() != 2 || fs_at[0] != 0 || fs_at[1] != FTA) begin
      n_fail++; $display("FAIL frame_period: got %0d pulses at %0d,%0d expected 2 at 0,%0d", fs_at.size(), fs_at[0], fs_at[1], FTA);
    end
  endtask

  task automatic test_small_params();
    exp_t o;
    logic [11:0] hs_mask = '0;
    logic [6:0]  vs_mask = '0;
    int de_cnt = 0;
    reset_s();
    ifs.mode = 2'd2;
    for (int i = 0; i < 2 * FTS + 3; i++) begin
      step_s(1'b1);
      o = obs_s(); n_chk++;
      if (o !== es) begin n_fail++; $display("FAIL small_model pix %0d: got %h expected %h", ps, o, es); end
      if (ps < FTS) begin
        if (o.hs) hs_mask[ps % HTS] = 1'b1;
        if (o.vs) vs_mask[ps / HTS] = 1'b1;
        if (o.de) de_cnt++;
      end
    end
    n_chk++;
    if (hs_mask !== 12'h600) begin n_fail++; $display("FAIL small_hs_cols: got %h expected 600", hs_mask); end
    n_chk++;
    if (vs_mask !== 7'h20) begin n_fail++; $display("FAIL small_vs_lines: got %h expected 20", vs_mask); end
    n_chk++;
    if (de_cnt != 32) begin n_fail++; $display("FAIL small_de_count: got %0d expected 32", de_cnt); end
  endtask

  task automatic test_pix_en_toggle();
    exp_t o, prev;
    int fs_rise[$];
    logic pfs = 1'b0;
    reset_a();
    ifa.mode = 2'($urandom_range(0, 3));
    prev = obs_a();
    for (int i = 0; i < 2 * FTA + 6; i++) begin
      step_a(i % 2 == 0);
      o = obs_a(); n_chk++;
      if (o !== ea) begin n_fail++; $display("FAIL toggle_model step %0d: got %h expected %h", i, o, ea); end
      if (i % 2 == 1) begin
        n_chk++;
        if (o !== prev) begin n_fail++; $display("FAIL toggle_hold step %0d: got %h expected %h", i, o, prev); end
      end
      if (o.fs && !pfs) fs_rise.push_back(cyc);
      pfs = o.fs; prev = o;
    end
    n_chk++;
    if (fs_rise.size() < 2 || fs_rise[1] - fs_rise[0] != 2 * FTA) begin
      n_fail++; $display("FAIL toggle_frame_period: got %0d expected %0d", fs_rise[1] - fs_rise[0], 2 * FTA);
    end
  endtask

  task automatic test_mode_switch();
    exp_t o;
    reset_a();
    ifa.mode = 2'd1;
    for (int i = 0; i < FTA + 41; i++) begin
      step_a(1'b1);
      if (pa == 3 * HTA + 100) ifa.mode = 2'd2;
      o = obs_a(); n_chk++;
      if (o !== ea) begin n_fail++; $display("FAIL switch_model pix %0d: got %h expected %h", pa, o, ea); end
      if (pa < FTA && o.de && o.y == 5 && (o.x < 80 || o.x >= 560)) begin
        n_chk++;
        if ({o.r, o.g, o.b} !== ((o.x < 80) ? 12'hFFF : 12'h000))
          begin n_fail++; $display("FAIL bars_persist x=%0d: got %h expected %h", o.x, {o.r, o.g, o.b}, (o.x < 80) ? 12'hFFF : 12'h000); end
      end
      if (pa == FTA) begin
        n_chk++;
        if ({o.fs, o.x, o.y, o.r, o.g, o.b} !== {1'b1, 16'd0, 16'd0, 12'hFFF})
          begin n_fail++; $display("FAIL checker_origin: got fs=%b x=%0d y=%0d rgb=%h expected 1 0 0 fff", o.fs, o.x, o.y, {o.r, o.g, o.b}); end
      end
      if (pa == FTA + 32) begin
        n_chk++;
        if ({o.x, o.r, o.g, o.b} !== {16'd32, 12'h000})
          begin n_fail++; $display("FAIL checker_32: got x=%0d rgb=%h expected 32 000", o.x, {o.r, o.g, o.b}); end
      end
    end
  endtask

  task automatic test_gradient();
    exp_t o;
    int tgt;
    tgt = 60 * HTB + 90;
    reset_b();
    ifb.mode = 2'd3;
    for (int i = 0; i < tgt + 50; i++) begin
      step_b(1'b1);
      o = obs_b(); n_chk++;
      if (o !== eb) begin n_fail++; $display("FAIL gradient_model pix %0d: got %h expected %h", pb, o, eb); end
      if (pb == tgt) begin
        n_chk++;
        if ({o.x, o.y, o.r, o.g, o.b} !== {16'd90, 16'd60, 12'h536})
          begin n_fail++; $display("FAIL gradient_px: got x=%0d y=%0d rgb=%h expected 90 60 536", o.x, o.y, {o.r, o.g, o.b}); end
      end
      if (pb == 60 * HTB + 136) begin
        n_chk++;
        if ({o.de, o.r, o.g, o.b} !== 13'h0)
          begin n_fail++; $display("FAIL gradient_blank: got de=%b rgb=%h expected 0 000", o.de, {o.r, o.g, o.b}); end
      end
    end
  endtask

  task automatic test_reset_mid_line();
    exp_t o;
    reset_a();
    ifa.mode = 2'd1;
    for (int i = 0; i < 301; i++) step_a(1'b1);
    #2; rst_a = 1'b0; #1;
    pa = -1; fma = 0; ea = model(CA, -1, 0);
    o = obs_a(); n_chk++;
    if (o !== ea) begin n_fail++; $display("FAIL midline_async: got %h expected %h", o, ea); end
    step_a(1'b1); step_a(1'b1);
    o = obs_a(); n_chk++;
    if (o !== ea) begin n_fail++; $display("FAIL midline_held: got %h expected %h", o, ea); end
    rst_a = 1'b1;
    step_a(1'b1);
    o = obs_a(); n_chk++;
    if ({o.x, o.y, o.fs} !== {16'd0, 16'd0, 1'b1})
      begin n_fail++; $display("FAIL midline_restart: got x=%0d y=%0d fs=%b expected 0 0 1", o.x, o.y, o.fs); end
    n_chk++;
    if (o !== ea) begin n_fail++; $display("FAIL midline_restart_model: got %h expected %h", o, ea); end
  endtask

  task automatic test_random();
    exp_t o;
    reset_s();
    ifs.mode = 2'($urandom_range(0, 3));
    for (int i = 0; i < 800; i++) begin
      step_s($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) ifs.mode = 2'($urandom_range(0, 3));
      o = obs_s(); n_chk++;
      if (o !== es) begin n_fail++; $display("FAIL random_model step %0d: got %h expected %h", i, o, es); end
    end
  endtask

  initial begin
    ifa.pix_en = 1'b0; ifb.pix_en = 1'b0; ifs.pix_en = 1'b0;
    ifa.mode = 2'd0;   ifb.mode = 2'd0;   ifs.mode = 2'd0;
    test_reset();
    test_default_timing();
    test_small_params();
    test_pix_en_toggle();
    test_mode_switch();
    test_gradient();
    test_reset_mid_line();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
